// File: rtl/mdio_rx_c45.sv
// PHY-side MDIO receiver: decodes Clause 22/45 frames and drives register-file strobes and read data.
// Inputs are sampled on the MDC rising edge, and all outputs are registered, so each output changes one edge after the bit that causes it.
module mdio_rx_c45 #(
    parameter logic [4:0] PHY_ADDR     = 5'd0,
    parameter int         PREAMBLE_MIN = 32,
    parameter bit         C45_EN       = 1'b1
) (
    input  logic        MDC,
    input  logic        RESET,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    input  logic [15:0] RD_DATA,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic [15:0] ADDR,
    output logic [4:0]  DEVAD,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    output logic        MDIO_DONE,
    output logic        FRAME_ERR,
    output logic        C45
);
    typedef enum logic [3:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
    } state_t;

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);

    state_t      state, state_nxt;
    logic [4:0]  bit_idx;
    logic [5:0]  pre_cnt;
    logic [14:0] sh;
    logic [15:0] word;
    logic [15:0] rd_sh;
    logic [15:0] addr_reg;
    logic        f_c45;
    logic [1:0]  f_op;

    logic station_bit, abort, start, hdr_ok, phy_ok, ta_ok;
    logic is_read, is_addr, is_inc;
    logic hdr_edge, reg_edge, wr_end, rd_end, err_nxt;

    // word always holds the most recent 16 sampled bits, newest in the LSB
    assign word        = {sh, MDIO_OUT};
    assign station_bit = (state == S_ST) || (state == S_OP) || (state == S_PHYAD) ||
                         (state == S_REGAD) || (state == S_TA) || (state == S_WDATA);
    assign abort       = station_bit && !MDIO_OE;
    assign start       = (state == S_IDLE) && MDIO_OE && !MDIO_OUT && (pre_cnt >= PRE_MIN);
    assign hdr_ok      = ((word[3:2] == 2'b01) && ((word[1:0] == 2'b01) || (word[1:0] == 2'b10))) ||
                         ((word[3:2] == 2'b00) && C45_EN);
    assign phy_ok      = (word[4:0] == PHY_ADDR);
    assign ta_ok       = (word[1:0] == 2'b10);
    assign is_read     = f_c45 ? f_op[1] : (f_op == 2'b10);
    assign is_addr     = f_c45 && (f_op == 2'b00);
    assign is_inc      = f_c45 && (f_op == 2'b10);

    always_ff @(posedge MDC or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_ST;
                S_ST:    state_nxt = S_OP;
                S_OP:    if (bit_idx == 5'd3)  state_nxt = hdr_ok ? S_PHYAD : S_IDLE;
                S_PHYAD: if (bit_idx == 5'd8)  state_nxt = phy_ok ? S_REGAD : S_SKIP;
                S_REGAD: if (bit_idx == 5'd13) state_nxt = is_read ? S_RDATA : S_TA;
                S_TA:    if (bit_idx == 5'd15) state_nxt = ta_ok ? S_WDATA : S_IDLE;
                S_WDATA, S_RDATA, S_SKIP:
                         if (bit_idx == 5'd31) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        hdr_edge = (state == S_OP)    && (bit_idx == 5'd3)  && !abort;
        reg_edge = (state == S_REGAD) && (bit_idx == 5'd13) && !abort;
        wr_end   = (state == S_WDATA) && (bit_idx == 5'd31) && !abort;
        rd_end   = (state == S_RDATA) && (bit_idx == 5'd31);
        err_nxt  = abort || (hdr_edge && !hdr_ok) ||
                   ((state == S_TA) && (bit_idx == 5'd15) && !abort && !ta_ok);
    end

    always_ff @(posedge MDC or posedge RESET) begin
        if (RESET) begin
            bit_idx    <= '0;
            pre_cnt    <= '0;
            sh         <= '0;
            rd_sh      <= '0;
            addr_reg   <= '0;
            f_c45      <= 1'b0;
            f_op       <= '0;
            MDIO_IN    <= 1'b0;
            MDIO_IN_OE <= 1'b0;
            ADDR       <= '0;
            DEVAD      <= '0;
            WR_DATA    <= '0;
            WR_STB     <= 1'b0;
            RD_STB     <= 1'b0;
            MDIO_DONE  <= 1'b0;
            FRAME_ERR  <= 1'b0;
            C45        <= 1'b0;
        end else begin
            WR_STB    <= wr_end && !is_addr;
            RD_STB    <= reg_edge && is_read;
            MDIO_DONE <= wr_end || rd_end;
            FRAME_ERR <= err_nxt;
            sh        <= word[14:0];
            bit_idx   <= (state == S_IDLE) ? 5'd1 : bit_idx + 5'd1;

            // Preamble count saturates at 32; any 0 or released line restarts it
            if ((state == S_IDLE) && MDIO_OE && MDIO_OUT) begin
                if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
            end else begin
                pre_cnt <= '0;
            end

            if (hdr_edge) begin
                f_c45 <= (word[3:2] == 2'b00);
                f_op  <= word[1:0];
            end

            if (reg_edge) begin
                C45   <= f_c45;
                DEVAD <= f_c45 ? word[4:0] : 5'd0;
                ADDR  <= f_c45 ? addr_reg : {11'd0, word[4:0]};
            end

            if (wr_end) begin
                if (is_addr) begin
                    addr_reg <= word;
                    ADDR     <= word;
                end else begin
                    WR_DATA  <= word;
                end
            end

            // Read turnaround: drive 0 after edge 14, then the latched word MSB first
            if (state == S_RDATA) begin
                if (bit_idx == 5'd14) begin
                    rd_sh      <= RD_DATA;
                    MDIO_IN_OE <= 1'b1;
                    MDIO_IN    <= 1'b0;
                end else if (bit_idx == 5'd31) begin
                    MDIO_IN_OE <= 1'b0;
                    MDIO_IN    <= 1'b0;
                    if (is_inc) addr_reg <= addr_reg + 16'd1;
                end else begin
                    MDIO_IN <= rd_sh[15];
                    rd_sh   <= {rd_sh[14:0], 1'b0};
                end
            end
        end
    end
endmodule
